fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-issue two-operand forwarding unit. Forwards data to NSRC operands.
- Forwarding sources: EX/MEM, MEM/WB, and a registered writeback-hold entry.
- Detects load-use hazards and runs a stall FSM that asserts stall for exactly LOAD_LAT cycles.
- Sits between the ID/EX register and the ALU operand muxes; stall drives the IF/ID and ID/EX enables and the bubble-insert into EX/MEM.

Parameters:
DATA_W, 16, datapath width
REG_AW, 3, register-address width
NSRC, 2, number of operand ports checked in ID/EX
LOAD_LAT, 1, stall cycles per load-use hazard (1..15)
ZERO_REG_SKIP, 0, if 1, register 0 is never forwarded or hazard-checked

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush
id_ex_valid  input  1  ID/EX holds a real instruction
src_addr  input  NSRC*REG_AW  operand i register address at [i*REG_AW +: REG_AW]
src_valid  input  NSRC  operand i is read
ex_mem_dst  input  REG_AW  EX/MEM destination
ex_mem_wb  input  1  EX/MEM writes back
ex_mem_is_load  input  1  EX/MEM is a load; its data is not yet available
ex_mem_data  input  DATA_W  EX/MEM ALU result
mem_wb_dst  input  REG_AW  MEM/WB destination
mem_wb_wb  input  1  MEM/WB writes back
mem_wb_data  input  DATA_W  MEM/WB result
fwd_sel  output  NSRC*2  per operand: 0 none, 1 EX/MEM, 2 MEM/WB, 3 hold
fwd_data  output  NSRC*DATA_W  per-operand forwarded value, 0 when sel=0
stall  output  1  freeze IF/ID and ID/EX, insert bubble into EX/MEM

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, cnt=0, hold_valid=0, hold_dst=0, hold_data=0.
  - stall=0 while in reset.
- Match rule: operand i matches source S when all of the following hold: id_ex_valid, src_valid[i], S writes back, addresses are equal, and NOT (ZERO_REG_SKIP and addr==0).
- Forward priority per operand (combinational, zero latency):
  - EX/MEM non-load match → sel=1, data=ex_mem_data.
  - else MEM/WB match → sel=2, data=mem_wb_data.
  - else hold match (hold_valid) → sel=3, data=hold_data.
  - else sel=0, data=0.
- An EX/MEM match with ex_mem_is_load=1 is a load-use hit:
  - that operand gets sel=0, data=0; it does NOT fall through to lower sources.
- Hold register:
  - On each posedge with mem_wb_wb=1, captures mem_wb_dst and mem_wb_data and sets hold_valid=1.
  - Otherwise unchanged.
  - Bubbles do not disturb it.
- FSM states: IDLE and STALL; cnt is a 4-bit counter.
  - IDLE:
    - any load-use hit → stall=1 (combinational, same cycle).
    - If LOAD_LAT>1, next state STALL with cnt=LOAD_LAT-1; else remain IDLE.
  - STALL:
    - stall=1 unconditionally; new hits are ignored.
    - cnt decrements each cycle; when cnt==1, next state IDLE.
  - Net effect: exactly LOAD_LAT stall cycles per hazard.
  - After the stall the load result is forwarded from MEM/WB (LOAD_LAT=1) or from hold (LOAD_LAT≥2).
- Flush (synchronous, highest priority):
  - Next state IDLE, cnt=0, hold_valid=0.
  - In the flush cycle, stall is forced to 0.
  - Flush wins over a simultaneous hazard or hold capture.
- Multiple operands hitting the same load produce a single stall sequence.
- Reset mid-STALL aborts immediately to IDLE.
- Outputs are combinational from inputs plus the registered state; there are no combinational loops.

Test Plan:
- Two operands, src0=r3, src1=r5; ex_mem dst=r3 (wb, non-load), data=0x1234; mem_wb dst=r5, data=0xBEEF → fwd_sel={2,1}, data0=0x1234, data1=0xBEEF, stall=0.
- Priority: src0=r2 matches both EX/MEM (0x0001) and MEM/WB (0x0002) → sel0=1, data0=0x0001. Next cycle EX/MEM wb=0 → sel0=2, data0=0x0002.
- Load-use, LOAD_LAT=1:
  - ex_mem dst=r4 is_load; src0=r4 → stall=1 for exactly 1 cycle, sel0=0.
  - Next cycle mem_wb dst=r4, data=0xCAFE → stall=0, sel0=2, data0=0xCAFE.
- LOAD_LAT=3: load-use hit → stall high for 3 consecutive cycles regardless of new hits. Load data 0x5A5A retires during the stall → after the stall, sel0=3, data0=0x5A5A.
- ZERO_REG_SKIP=1: src0=r0 while EX/MEM dst=r0 is_load → stall=0, sel0=0. With ZERO_REG_SKIP=0 → stall=1.
- Flush in the 2nd cycle of a LOAD_LAT=3 stall → stall=0 that cycle, IDLE next, hold_valid=0. Async rst_n pulse mid-STALL → stall drops immediately and hold is cleared.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding from EX/MEM, MEM/WB and a writeback-hold
// entry, plus load-use hazard detection with a fixed-length stall sequence.
// Outputs are combinational from the current inputs and the registered state.
module fwd_hazard_unit #(
  parameter int DATA_W        = 16,
  parameter int REG_AW        = 3,
  parameter int NSRC          = 2,
  parameter int LOAD_LAT      = 1,
  parameter int ZERO_REG_SKIP = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     id_ex_valid,
  input  logic [NSRC*REG_AW-1:0]   src_addr,
  input  logic [NSRC-1:0]          src_valid,
  input  logic [REG_AW-1:0]        ex_mem_dst,
  input  logic                     ex_mem_wb,
  input  logic                     ex_mem_is_load,
  input  logic [DATA_W-1:0]        ex_mem_data,
  input  logic [REG_AW-1:0]        mem_wb_dst,
  input  logic                     mem_wb_wb,
  input  logic [DATA_W-1:0]        mem_wb_data,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic [NSRC*DATA_W-1:0]   fwd_data,
  output logic                     stall
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Register 0 is excluded from matching when this is set.
  localparam logic       ZSKIP    = (ZERO_REG_SKIP != 0);
  // A single-cycle stall needs no STALL state at all.
  localparam logic       MULTI    = (LOAD_LAT > 1);
  localparam logic [3:0] LAT_M1   = 4'(LOAD_LAT - 1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [3:0]            cnt_r;
  logic [3:0]            cnt_nxt_s;
  logic                  hold_valid_r;
  logic [REG_AW-1:0]     hold_dst_r;
  logic [DATA_W-1:0]     hold_data_r;
  logic [NSRC-1:0]       load_hit_s;
  logic                  any_hit_s;
  logic                  stall_s;

  // An operand read matches a writer when the read is live, the writer writes
  // back, the addresses agree, and the address is not a skipped zero register.
  function automatic logic src_match(
    input logic              rd_live,
    input logic [REG_AW-1:0] rd_addr,
    input logic              wr_en,
    input logic [REG_AW-1:0] wr_addr
  );
    logic zero_skip;
    zero_skip = ZSKIP && (rd_addr == {REG_AW{1'b0}});
    return rd_live && wr_en && (rd_addr == wr_addr) && !zero_skip;
  endfunction

  // Per-operand forward select with EX/MEM > MEM/WB > hold priority; a load in
  // EX/MEM blocks the operand completely instead of falling through.
  always_comb begin
    fwd_sel    = '0;
    fwd_data   = '0;
    load_hit_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_match(id_ex_valid && src_valid[i], src_addr[i*REG_AW +: REG_AW],
                    ex_mem_wb, ex_mem_dst)) begin
        if (ex_mem_is_load) begin
          load_hit_s[i] = 1'b1;
        end else begin
          fwd_sel[i*2 +: 2]           = 2'd1;
          fwd_data[i*DATA_W +: DATA_W] = ex_mem_data;
        end
      end else if (src_match(id_ex_valid && src_valid[i], src_addr[i*REG_AW +: REG_AW],
                             mem_wb_wb, mem_wb_dst)) begin
        fwd_sel[i*2 +: 2]           = 2'd2;
        fwd_data[i*DATA_W +: DATA_W] = mem_wb_data;
      end else if (src_match(id_ex_valid && src_valid[i], src_addr[i*REG_AW +: REG_AW],
                             hold_valid_r, hold_dst_r)) begin
        fwd_sel[i*2 +: 2]           = 2'd3;
        fwd_data[i*DATA_W +: DATA_W] = hold_data_r;
      end else begin
        fwd_sel[i*2 +: 2]           = 2'd0;
        fwd_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  // Several operands hitting the same load collapse into one stall sequence.
  assign any_hit_s = |load_hit_s;

  // Stall FSM next-state and stall decode; flush overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    if (flush) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = 4'd0;
      stall_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_hit_s) begin
            stall_s = 1'b1;
            if (MULTI) begin
              state_nxt_s = STALL;
              cnt_nxt_s   = LAT_M1;
            end else begin
              state_nxt_s = IDLE;
              cnt_nxt_s   = 4'd0;
            end
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
          end
        end
        STALL: begin
          stall_s = 1'b1;
          if (cnt_r == 4'd1) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = STALL;
            cnt_nxt_s   = cnt_r - 4'd1;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
          stall_s     = 1'b0;
        end
      endcase
    end
  end

  // Stall is held low for the whole reset window, even with a hit on the inputs.
  assign stall = stall_s && rst_n;

  // Stall FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Writeback-hold entry: remembers the last MEM/WB write; flush invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_r <= 1'b0;
      hold_dst_r   <= {REG_AW{1'b0}};
      hold_data_r  <= {DATA_W{1'b0}};
    end else if (flush) begin
      hold_valid_r <= 1'b0;
    end else if (mem_wb_wb) begin
      hold_valid_r <= 1'b1;
      hold_dst_r   <= mem_wb_dst;
      hold_data_r  <= mem_wb_data;
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: two instances (LOAD_LAT=1/ZERO_REG_SKIP=0 and
// LOAD_LAT=3/ZERO_REG_SKIP=1) share stimulus; directed scenarios plus a random
// run checked against a behavioural model.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        id_ex_valid;
  logic [5:0]  src_addr;
  logic [1:0]  src_valid;
  logic [2:0]  ex_mem_dst;
  logic        ex_mem_wb;
  logic        ex_mem_is_load;
  logic [15:0] ex_mem_data;
  logic [2:0]  mem_wb_dst;
  logic        mem_wb_wb;
  logic [15:0] mem_wb_data;
  logic [3:0]  sel_a, sel_b;
  logic [31:0] data_a, data_b;
  logic        stall_a, stall_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state per instance: remaining stall cycles and the hold entry.
  int          m_left [2];
  logic        m_hv   [2];
  logic [2:0]  m_hd   [2];
  logic [15:0] m_hdat [2];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DATA_W(16), .REG_AW(3), .NSRC(2), .LOAD_LAT(1), .ZERO_REG_SKIP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_ex_valid(id_ex_valid),
    .src_addr(src_addr), .src_valid(src_valid),
    .ex_mem_dst(ex_mem_dst), .ex_mem_wb(ex_mem_wb), .ex_mem_is_load(ex_mem_is_load),
    .ex_mem_data(ex_mem_data), .mem_wb_dst(mem_wb_dst), .mem_wb_wb(mem_wb_wb),
    .mem_wb_data(mem_wb_data), .fwd_sel(sel_a), .fwd_data(data_a), .stall(stall_a)
  );

  fwd_hazard_unit #(.DATA_W(16), .REG_AW(3), .NSRC(2), .LOAD_LAT(3), .ZERO_REG_SKIP(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_ex_valid(id_ex_valid),
    .src_addr(src_addr), .src_valid(src_valid),
    .ex_mem_dst(ex_mem_dst), .ex_mem_wb(ex_mem_wb), .ex_mem_is_load(ex_mem_is_load),
    .ex_mem_data(ex_mem_data), .mem_wb_dst(mem_wb_dst), .mem_wb_wb(mem_wb_wb),
    .mem_wb_data(mem_wb_data), .fwd_sel(sel_b), .fwd_data(data_b), .stall(stall_b)
  );

  task automatic clear_inputs();
    flush = 1'b0; id_ex_valid = 1'b0; src_addr = 6'd0; src_valid = 2'b00;
    ex_mem_dst = 3'd0; ex_mem_wb = 1'b0; ex_mem_is_load = 1'b0; ex_mem_data = 16'h0000;
    mem_wb_dst = 3'd0; mem_wb_wb = 1'b0; mem_wb_data = 16'h0000;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Spec-level model: priority list per operand, stall if cycles remain or a hit.
  function automatic void model_eval(input int k, output logic [3:0] sel,
                                     output logic [31:0] data, output logic st,
                                     output logic hit);
    logic [2:0] a;
    logic       live;
    sel = 4'd0; data = 32'd0; hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = src_addr[i*3 +: 3];
      live = id_ex_valid && src_valid[i] && !(k == 1 && a == 3'd0);
      if (live && ex_mem_wb && ex_mem_dst == a) begin
        if (ex_mem_is_load) hit = 1'b1;
        else begin sel[i*2 +: 2] = 2'd1; data[i*16 +: 16] = ex_mem_data; end
      end else if (live && mem_wb_wb && mem_wb_dst == a) begin
        sel[i*2 +: 2] = 2'd2; data[i*16 +: 16] = mem_wb_data;
      end else if (live && m_hv[k] && m_hd[k] == a) begin
        sel[i*2 +: 2] = 2'd3; data[i*16 +: 16] = m_hdat[k];
      end
    end
    st = flush ? 1'b0 : (m_left[k] > 0 || hit);
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    id_ex_valid = 1'b1; src_valid = 2'b01; src_addr = {3'd0, 3'd4};
    ex_mem_dst = 3'd4; ex_mem_wb = 1'b1; ex_mem_is_load = 1'b1;
    @(negedge clk); #1;
    total_cnt++; if (stall_a !== 1'b0) $display("FAIL reset_stall_a got=%b exp=0", stall_a); else pass_cnt++;
    total_cnt++; if (stall_b !== 1'b0) $display("FAIL reset_stall_b got=%b exp=0", stall_b); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    id_ex_valid = 1'b1; src_valid = 2'b11; src_addr = {3'd1, 3'd0};
    #1;
    total_cnt++; if (sel_a !== 4'd0 || data_a !== 32'd0) $display("FAIL reset_hold_a sel=%h data=%h exp=0/0", sel_a, data_a); else pass_cnt++;
    total_cnt++; if (stall_a !== 1'b0) $display("FAIL reset_idle_a got=%b exp=0", stall_a); else pass_cnt++;
  endtask

  task automatic test_basic();
    apply_reset();
    id_ex_valid = 1'b1; src_valid = 2'b11; src_addr = {3'd5, 3'd3};
    ex_mem_dst = 3'd3; ex_mem_wb = 1'b1; ex_mem_data = 16'h1234;
    mem_wb_dst = 3'd5; mem_wb_wb = 1'b1; mem_wb_data = 16'hBEEF;
    #1;
    total_cnt++; if (sel_a !== 4'b1001) $display("FAIL basic_sel_a got=%h exp=9", sel_a); else pass_cnt++;
    total_cnt++; if (data_a !== 32'hBEEF1234) $display("FAIL basic_data_a got=%h exp=beef1234", data_a); else pass_cnt++;
    total_cnt++; if (sel_b !== 4'b1001 || data_b !== 32'hBEEF1234) $display("FAIL basic_b sel=%h data=%h exp=9/beef1234", sel_b, data_b); else pass_cnt++;
    total_cnt++; if (stall_a !== 1'b0) $display("FAIL basic_stall got=%b exp=0", stall_a); else pass_cnt++;
  endtask

  task automatic test_priority();
    apply_reset();
    id_ex_valid = 1'b1; src_valid = 2'b01; src_addr = {3'd7, 3'd2};
    ex_mem_dst = 3'd2; ex_mem_wb = 1'b1; ex_mem_data = 16'h0001;
    mem_wb_dst = 3'd2; mem_wb_wb = 1'b1; mem_wb_data = 16'h0002;
    #1;
    total_cnt++; if (sel_a !== 4'd1 || data_a[15:0] !== 16'h0001) $display("FAIL prio_ex sel=%h data=%h exp=1/0001", sel_a, data_a[15:0]); else pass_cnt++;
    @(negedge clk);
    ex_mem_wb = 1'b0;
    #1;
    total_cnt++; if (sel_a !== 4'd2 || data_a[15:0] !== 16'h0002) $display("FAIL prio_mw sel=%h data=%h exp=2/0002", sel_a, data_a[15:0]); else pass_cnt++;
  endtask

  task automatic test_load_use_lat1();
    apply_reset();
    id_ex_valid = 1'b1; src_valid = 2'b01; src_addr = {3'd0, 3'd4};
    ex_mem_dst = 3'd4; ex_mem_wb = 1'b1; ex_mem_is_load = 1'b1; ex_mem_data = 16'h7777;
    mem_wb_dst = 3'd4; mem_wb_wb = 1'b1; mem_wb_data = 16'h1111;
    #1;
    total_cnt++; if (stall_a !== 1'b1) $display("FAIL lu1_stall got=%b exp=1", stall_a); else pass_cnt++;
    total_cnt++; if (sel_a !== 4'd0 || data_a !== 32'd0) $display("FAIL lu1_nofall sel=%h data=%h exp=0/0", sel_a, data_a); else pass_cnt++;
    @(negedge clk);
    ex_mem_wb = 1'b0; ex_mem_is_load = 1'b0;
    mem_wb_data = 16'hCAFE;
    #1;
    total_cnt++; if (stall_a !== 1'b0) $display("FAIL lu1_release got=%b exp=0", stall_a); else pass_cnt++;
    total_cnt++; if (sel_a !== 4'd2 || data_a[15:0] !== 16'hCAFE) $display("FAIL lu1_fwd sel=%h data=%h exp=2/cafe", sel_a, data_a[15:0]); else pass_cnt++;
    total_cnt++; if (stall_b !== 1'b1) $display("FAIL lu1_b_still got=%b exp=1", stall_b); else pass_cnt++;
  endtask

  task automatic test_load_use_lat3();
    logic exp_st [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    id_ex_valid = 1'b1; src_valid = 2'b01; src_addr = {3'd0, 3'd4};
    ex_mem_dst = 3'd4; ex_mem_wb = 1'b1; ex_mem_is_load = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      mem_wb_wb = (c == 1); mem_wb_dst = 3'd4; mem_wb_data = 16'h5A5A;
      ex_mem_wb = (c < 3);
      #1;
      total_cnt++; if (stall_b !== exp_st[c]) $display("FAIL lu3_stall c=%0d got=%b exp=%b", c, stall_b, exp_st[c]); else pass_cnt++;
    end
    total_cnt++; if (sel_b !== 4'd3 || data_b[15:0] !== 16'h5A5A) $display("FAIL lu3_hold sel=%h data=%h exp=3/5a5a", sel_b, data_b[15:0]); else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    apply_reset();
    id_ex_valid = 1'b1; src_valid = 2'b01; src_addr = 6'd0;
    ex_mem_dst = 3'd0; ex_mem_wb = 1'b1; ex_mem_is_load = 1'b1;
    #1;
    total_cnt++; if (stall_b !== 1'b0 || sel_b !== 4'd0) $display("FAIL zero_skip stall=%b sel=%h exp=0/0", stall_b, sel_b); else pass_cnt++;
    total_cnt++; if (stall_a !== 1'b1) $display("FAIL zero_noskip got=%b exp=1", stall_a); else pass_cnt++;
  endtask

  task automatic test_flush();
    apply_reset();
    id_ex_valid = 1'b1; src_valid = 2'b01; src_addr = {3'd0, 3'd4};
    ex_mem_dst = 3'd4; ex_mem_wb = 1'b1; ex_mem_is_load = 1'b1;
    mem_wb_dst = 3'd6; mem_wb_wb = 1'b1; mem_wb_data = 16'h7777;
    #1;
    total_cnt++; if (stall_b !== 1'b1) $display("FAIL flush_pre got=%b exp=1", stall_b); else pass_cnt++;
    @(negedge clk);
    flush = 1'b1; ex_mem_wb = 1'b0; mem_wb_data = 16'h8888;
    #1;
    total_cnt++; if (stall_b !== 1'b0 || stall_a !== 1'b0) $display("FAIL flush_cycle a=%b b=%b exp=0/0", stall_a, stall_b); else pass_cnt++;
    @(negedge clk);
    flush = 1'b0; mem_wb_wb = 1'b0; src_addr = {3'd0, 3'd6};
    #1;
    total_cnt++; if (stall_b !== 1'b0) $display("FAIL flush_idle got=%b exp=0", stall_b); else pass_cnt++;
    total_cnt++; if (sel_b !== 4'd0 || sel_a !== 4'd0) $display("FAIL flush_hold a=%h b=%h exp=0/0", sel_a, sel_b); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    id_ex_valid = 1'b1; src_valid = 2'b11; src_addr = {3'd6, 3'd4};
    ex_mem_dst = 3'd4; ex_mem_wb = 1'b1; ex_mem_is_load = 1'b1;
    mem_wb_dst = 3'd6; mem_wb_wb = 1'b1; mem_wb_data = 16'h9999;
    @(negedge clk);
    ex_mem_wb = 1'b0; mem_wb_wb = 1'b0;
    #1;
    total_cnt++; if (stall_b !== 1'b1) $display("FAIL arst_pre got=%b exp=1", stall_b); else pass_cnt++;
    total_cnt++; if (sel_b[3:2] !== 2'd3 || data_b[31:16] !== 16'h9999) $display("FAIL arst_hold sel=%h data=%h exp=3/9999", sel_b[3:2], data_b[31:16]); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if (stall_b !== 1'b0) $display("FAIL arst_drop got=%b exp=0", stall_b); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (stall_b !== 1'b0 || sel_b !== 4'd0) $display("FAIL arst_after stall=%b sel=%h exp=0/0", stall_b, sel_b); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0]  e_sel  [2];
    logic [31:0] e_dat  [2];
    logic        e_st   [2];
    logic        e_hit  [2];
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_hv[k] = 1'b0; m_hd[k] = 3'd0; m_hdat[k] = 16'h0000;
    end
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge clk);
      flush          = ($urandom_range(0, 15) == 0);
      id_ex_valid    = ($urandom_range(0, 7) != 0);
      src_addr       = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      src_valid      = 2'($urandom_range(0, 3));
      ex_mem_dst     = 3'($urandom_range(0, 3));
      ex_mem_wb      = 1'($urandom_range(0, 1));
      ex_mem_is_load = ($urandom_range(0, 3) == 0);
      ex_mem_data    = 16'($urandom);
      mem_wb_dst     = 3'($urandom_range(0, 3));
      mem_wb_wb      = 1'($urandom_range(0, 1));
      mem_wb_data    = 16'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        model_eval(k, e_sel[k], e_dat[k], e_st[k], e_hit[k]);
      end
      total_cnt++; if (sel_a !== e_sel[0]) $display("FAIL rnd_sel_a n=%0d got=%h exp=%h", n, sel_a, e_sel[0]); else pass_cnt++;
      total_cnt++; if (data_a !== e_dat[0]) $display("FAIL rnd_data_a n=%0d got=%h exp=%h", n, data_a, e_dat[0]); else pass_cnt++;
      total_cnt++; if (stall_a !== e_st[0]) $display("FAIL rnd_stall_a n=%0d got=%b exp=%b", n, stall_a, e_st[0]); else pass_cnt++;
      total_cnt++; if (sel_b !== e_sel[1]) $display("FAIL rnd_sel_b n=%0d got=%h exp=%h", n, sel_b, e_sel[1]); else pass_cnt++;
      total_cnt++; if (data_b !== e_dat[1]) $display("FAIL rnd_data_b n=%0d got=%h exp=%h", n, data_b, e_dat[1]); else pass_cnt++;
      total_cnt++; if (stall_b !== e_st[1]) $display("FAIL rnd_stall_b n=%0d got=%b exp=%b", n, stall_b, e_st[1]); else pass_cnt++;
      // Advance the model to reflect the coming rising edge.
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          m_left[k] = 0; m_hv[k] = 1'b0;
        end else begin
          if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
          else if (e_hit[k]) m_left[k] = (k == 0) ? 0 : 2;
          if (mem_wb_wb) begin
            m_hv[k] = 1'b1; m_hd[k] = mem_wb_dst; m_hdat[k] = mem_wb_data;
          end
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_load_use_lat1();
    test_load_use_lat3();
    test_zero_reg();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
